// File: rtl/rocket_pkg.sv
// Shared types and constants for the rocket slot arbiter.
package rocket_pkg;

   typedef logic signed [10:0] coord_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      PAUSED = 2'd2
   } state_t;

   typedef enum logic {
      OWNER_PLAYER = 1'b0,
      OWNER_ALIEN  = 1'b1
   } owner_t;

   localparam coord_t PLAYER_X_OFFSET = 11'sd32;

endpackage

// File: rtl/rocket_slot_arbiter_if.sv
// Fire request/grant and launch-data bundle between fire sources and the arbiter.
interface rocket_slot_arbiter_if #(parameter int NUM_SLOTS = 5);
   import rocket_pkg::*;

   logic                 playerReq;
   coord_t               playerX;
   coord_t               playerY;
   logic                 alienReq;
   coord_t               alienX;
   coord_t               alienY;
   coord_t               alienSpeed;
   logic                 playerGnt;
   logic                 alienGnt;
   logic [NUM_SLOTS-1:0] slotLoad;
   coord_t               initialX;
   coord_t               initialY;
   coord_t               initialSpeed;

   modport master (
      output playerReq, playerX, playerY, alienReq, alienX, alienY, alienSpeed,
      input  playerGnt, alienGnt, slotLoad, initialX, initialY, initialSpeed
   );

   modport slave (
      input  playerReq, playerX, playerY, alienReq, alienX, alienY, alienSpeed,
      output playerGnt, alienGnt, slotLoad, initialX, initialY, initialSpeed
   );

endinterface

// File: rtl/rocket_slot_arbiter_slot_pool.sv
// Rocket slot busy mask, owner bits, lowest-free selection and per-owner counts.
module slot_pool
   import rocket_pkg::*;
#(
   parameter int NUM_SLOTS = 5
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 alloc,
   input  owner_t               alloc_owner,
   input  logic [NUM_SLOTS-1:0] rel_mask,
   output logic [NUM_SLOTS-1:0] free_slot,
   output logic                 any_free,
   output logic [NUM_SLOTS-1:0] active,
   output logic [NUM_SLOTS-1:0] owner,
   output logic [2:0]           player_count,
   output logic [2:0]           alien_count
);

   logic [NUM_SLOTS-1:0] rel_hit;
   logic [NUM_SLOTS-1:0] alloc_mask;
   logic [2:0]           rel_player;
   logic [2:0]           rel_alien;
   logic                 alloc_player;
   logic                 alloc_alien;

   // lowest clear bit of the registered mask; zero when the pool is full
   assign free_slot    = ~active & (active + 1'b1);
   assign any_free     = ~&active;
   assign rel_hit      = rel_mask & active;
   assign alloc_mask   = alloc ? free_slot : '0;
   assign alloc_player = alloc && any_free && (alloc_owner == OWNER_PLAYER);
   assign alloc_alien  = alloc && any_free && (alloc_owner == OWNER_ALIEN);

   always_comb begin
      rel_player = '0;
      rel_alien  = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (rel_hit[i]) begin
            if (owner[i]) rel_alien = rel_alien + 3'd1;
            else          rel_player = rel_player + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         active       <= '0;
         owner        <= '0;
         player_count <= '0;
         alien_count  <= '0;
      end else begin
         active       <= (active & ~rel_hit) | alloc_mask;
         owner        <= (owner & ~alloc_mask) | (alloc_alien ? alloc_mask : '0);
         player_count <= player_count - rel_player + {2'b00, alloc_player};
         alien_count  <= alien_count - rel_alien + {2'b00, alloc_alien};
      end
   end

endmodule

// File: rtl/rocket_slot_arbiter.sv
// Shares the rocket slot pool between player and alien fire with quotas,
// frame cooldowns and round-robin arbitration.
//
//   state  | meaning
//   IDLE   | sample requests, pick a winner
//   GRANT  | grant/load strobe high for one cycle
//   PAUSED | allocation and cooldowns frozen, releases still honoured
module rocket_slot_arbiter
   import rocket_pkg::*;
#(
   parameter int NUM_SLOTS    = 5,
   parameter int PLAYER_MAX   = 2,
   parameter int ALIEN_MAX    = 3,
   parameter int PLAYER_CD    = 6,
   parameter int ALIEN_CD     = 3,
   parameter int PLAYER_SPEED = -128
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 startOfFrame,
   input  logic                 pause,
   input  logic [NUM_SLOTS-1:0] releaseSlot,
   rocket_slot_arbiter_if.slave fire,
   output logic [NUM_SLOTS-1:0] activeSlots,
   output logic [NUM_SLOTS-1:0] slotOwner,
   output logic [2:0]           playerCount,
   output logic [2:0]           alienCount
);

   localparam coord_t PLAYER_SPEED_C = coord_t'(PLAYER_SPEED);

   state_t               state;
   owner_t               last_winner;
   logic [2:0]           player_cd;
   logic [2:0]           alien_cd;
   logic [NUM_SLOTS-1:0] free_slot;
   logic                 any_free;
   logic                 player_ok;
   logic                 alien_ok;
   logic                 take;
   logic                 win_alien;

   assign player_ok = fire.playerReq && any_free && (playerCount < 3'(PLAYER_MAX)) && (player_cd == '0);
   assign alien_ok  = fire.alienReq && any_free && (alienCount < 3'(ALIEN_MAX)) && (alien_cd == '0);
   assign take      = (state == IDLE) && !pause && (player_ok || alien_ok);
   assign win_alien = alien_ok && (!player_ok || (last_winner == OWNER_PLAYER));

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (pause) state <= PAUSED;
                     else if (take) state <= GRANT;
            GRANT:   state <= pause ? PAUSED : IDLE;
            PAUSED:  if (!pause) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         fire.playerGnt    <= 1'b0;
         fire.alienGnt     <= 1'b0;
         fire.slotLoad     <= '0;
         fire.initialX     <= '0;
         fire.initialY     <= '0;
         fire.initialSpeed <= '0;
         last_winner       <= OWNER_ALIEN;
      end else begin
         fire.playerGnt <= take && !win_alien;
         fire.alienGnt  <= take && win_alien;
         fire.slotLoad  <= take ? free_slot : '0;
         if (take && win_alien) begin
            fire.initialX     <= fire.alienX;
            fire.initialY     <= fire.alienY;
            fire.initialSpeed <= fire.alienSpeed;
         end else if (take) begin
            fire.initialX     <= fire.playerX + PLAYER_X_OFFSET;
            fire.initialY     <= fire.playerY;
            fire.initialSpeed <= PLAYER_SPEED_C;
         end else begin
            fire.initialX     <= '0;
            fire.initialY     <= '0;
            fire.initialSpeed <= '0;
         end
         // round-robin pointer only moves on a contested grant
         if (take && player_ok && alien_ok)
            last_winner <= win_alien ? OWNER_ALIEN : OWNER_PLAYER;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         player_cd <= '0;
         alien_cd  <= '0;
      end else begin
         if (take && !win_alien)
            player_cd <= 3'(PLAYER_CD);
         else if (startOfFrame && !pause && (player_cd != '0))
            player_cd <= player_cd - 3'd1;

         if (take && win_alien)
            alien_cd <= 3'(ALIEN_CD);
         else if (startOfFrame && !pause && (alien_cd != '0))
            alien_cd <= alien_cd - 3'd1;
      end
   end

   slot_pool #(
      .NUM_SLOTS (NUM_SLOTS)
   ) u_slot_pool (
      .clk          (clk),
      .resetN       (resetN),
      .alloc        (take),
      .alloc_owner  (win_alien ? OWNER_ALIEN : OWNER_PLAYER),
      .rel_mask     (releaseSlot),
      .free_slot    (free_slot),
      .any_free     (any_free),
      .active       (activeSlots),
      .owner        (slotOwner),
      .player_count (playerCount),
      .alien_count  (alienCount)
   );

endmodule

// File: tb/tb_rocket_slot_arbiter.sv
// Scoreboard bench for rocket_slot_arbiter: predicted loads queued at stimulus, checked at slotLoad.
`timescale 1ns/1ps
module tb_rocket_slot_arbiter;

   localparam int NS = 5;

   logic          clk = 1'b0;
   logic          resetN = 1'b0;
   logic          startOfFrame = 1'b0;
   logic          pause = 1'b0;
   logic [NS-1:0] releaseSlot = '0;
   logic [NS-1:0] activeSlots;
   logic [NS-1:0] slotOwner;
   logic [2:0]    playerCount;
   logic [2:0]    alienCount;

   rocket_slot_arbiter_if #(.NUM_SLOTS(NS)) fif ();

   rocket_slot_arbiter #(.NUM_SLOTS(NS)) dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .pause        (pause),
      .releaseSlot  (releaseSlot),
      .fire         (fif),
      .activeSlots  (activeSlots),
      .slotOwner    (slotOwner),
      .playerCount  (playerCount),
      .alienCount   (alienCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            alien;
      logic [NS-1:0] slot;
      int            x;
      int            y;
      int            spd;
   } exp_t;

   exp_t          sb[$];
   int            n_tests = 0;
   int            n_fail = 0;
   int            n_pg = 0;
   int            n_ag = 0;
   bit            drop_p = 1'b0;
   bit            drop_a = 1'b0;
   logic [NS-1:0] m_active = '0;
   logic [NS-1:0] m_owner = '0;
   int            m_pc = 0;
   int            m_ac = 0;

   task automatic check(input string tag, input int obs, input int expv);
      n_tests++;
      if (obs != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   // one clock: drop requests granted last cycle, then sample at the falling edge
   task automatic cycle();
      exp_t e;
      @(posedge clk);
      #1;
      if (drop_p) begin fif.playerReq = 1'b0; drop_p = 1'b0; end
      if (drop_a) begin fif.alienReq = 1'b0; drop_a = 1'b0; end
      @(negedge clk);
      if (fif.slotLoad != '0) begin
         if (sb.size() == 0) begin
            check("spurious_load", int'(fif.slotLoad), 0);
         end else begin
            e = sb.pop_front();
            check("load_slot", int'(fif.slotLoad), int'(e.slot));
            check("load_gnt", int'({fif.alienGnt, fif.playerGnt}), e.alien ? 2 : 1);
            check("load_x", int'(fif.initialX), e.x);
            check("load_y", int'(fif.initialY), e.y);
            check("load_speed", int'(fif.initialSpeed), e.spd);
         end
         if (fif.playerGnt) begin n_pg++; drop_p = 1'b1; end
         if (fif.alienGnt)  begin n_ag++; drop_a = 1'b1; end
      end else if (fif.playerGnt || fif.alienGnt) begin
         check("gnt_without_load", int'({fif.alienGnt, fif.playerGnt}), 0);
      end
   endtask

   task automatic expect_grant(input bit alien);
      exp_t          e;
      logic [NS-1:0] s;
      s = '0;
      for (int i = NS - 1; i >= 0; i--) begin
         if (!m_active[i]) begin
            s = '0;
            s[i] = 1'b1;
         end
      end
      e.alien = alien;
      e.slot  = s;
      if (alien) begin
         e.x = int'(fif.alienX);
         e.y = int'(fif.alienY);
         e.spd = int'(fif.alienSpeed);
         m_owner = m_owner | s;
         m_ac++;
      end else begin
         e.x = int'(fif.playerX) + 32;
         e.y = int'(fif.playerY);
         e.spd = -128;
         m_owner = m_owner & ~s;
         m_pc++;
      end
      m_active = m_active | s;
      sb.push_back(e);
   endtask

   task automatic release_slots(input logic [NS-1:0] mask);
      for (int i = 0; i < NS; i++) begin
         if (mask[i] && m_active[i]) begin
            if (m_owner[i]) m_ac--;
            else            m_pc--;
            m_active[i] = 1'b0;
         end
      end
      releaseSlot = mask;
      cycle();
      releaseSlot = '0;
   endtask

   task automatic wait_gnt(input bit alien, input int max_cycles, input string tag);
      int start;
      int got;
      start = alien ? n_ag : n_pg;
      got = 0;
      for (int i = 0; i < max_cycles && got == 0; i++) begin
         cycle();
         if ((alien ? n_ag : n_pg) != start) got = 1;
      end
      check(tag, got, 1);
   endtask

   task automatic frames(input int n);
      for (int f = 0; f < n; f++) begin
         startOfFrame = 1'b1;
         cycle();
         startOfFrame = 1'b0;
         repeat (3) cycle();
      end
   endtask

   task automatic do_reset();
      check("sb_empty_at_reset", sb.size(), 0);
      fif.playerReq = 1'b0;
      fif.alienReq = 1'b0;
      pause = 1'b0;
      startOfFrame = 1'b0;
      releaseSlot = '0;
      drop_p = 1'b0;
      drop_a = 1'b0;
      resetN = 1'b0;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      m_active = '0;
      m_owner = '0;
      m_pc = 0;
      m_ac = 0;
      n_pg = 0;
      n_ag = 0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      fif.playerReq = 1'b0;
      fif.playerX = '0;
      fif.playerY = '0;
      fif.alienReq = 1'b0;
      fif.alienX = '0;
      fif.alienY = '0;
      fif.alienSpeed = '0;

      repeat (3) @(negedge clk);
      check("rst_active", int'(activeSlots), 0);
      check("rst_pcount", int'(playerCount), 0);
      check("rst_acount", int'(alienCount), 0);
      check("rst_load", int'(fif.slotLoad), 0);
      check("rst_gnt", int'({fif.alienGnt, fif.playerGnt}), 0);
      resetN = 1'b1;
      @(negedge clk);

      // first player shot from reset
      fif.playerX = 11'sd100;
      fif.playerY = 11'sd400;
      expect_grant(1'b0);
      fif.playerReq = 1'b1;
      cycle();
      check("t1_latency", n_pg, 1);
      check("t1_pcount", int'(playerCount), 1);
      check("t1_active", int'(activeSlots), 1);
      cycle();
      check("t1_strobe_len", int'(fif.slotLoad), 0);

      // contested requests, round-robin
      do_reset();
      fif.playerX = 11'sd10;
      fif.playerY = 11'sd20;
      fif.alienX = -11'sd50;
      fif.alienY = 11'sd30;
      fif.alienSpeed = 11'sd64;
      expect_grant(1'b0);
      expect_grant(1'b1);
      fif.playerReq = 1'b1;
      fif.alienReq = 1'b1;
      cycle();
      check("t2_c1_pg", n_pg, 1);
      check("t2_c1_ag", n_ag, 0);
      cycle();
      check("t2_spacing", n_ag, 0);
      cycle();
      check("t2_c3_ag", n_ag, 1);
      frames(7);
      expect_grant(1'b1);
      expect_grant(1'b0);
      fif.playerReq = 1'b1;
      fif.alienReq = 1'b1;
      wait_gnt(1'b0, 5, "t2_round2_player");
      check("t2_ag", n_ag, 2);
      check("t2_pcount", int'(playerCount), 2);
      check("t2_acount", int'(alienCount), 2);

      // player quota and release
      do_reset();
      fif.playerX = 11'sd50;
      fif.playerY = 11'sd60;
      expect_grant(1'b0);
      fif.playerReq = 1'b1;
      wait_gnt(1'b0, 3, "t3_g1");
      frames(6);
      expect_grant(1'b0);
      fif.playerReq = 1'b1;
      wait_gnt(1'b0, 3, "t3_g2");
      frames(6);
      fif.playerReq = 1'b1;
      repeat (10) cycle();
      check("t3_quota_block", n_pg, 2);
      check("t3_active", int'(activeSlots), 3);
      release_slots(5'b00010);
      expect_grant(1'b0);
      wait_gnt(1'b0, 2, "t3_regrant");
      check("t3_pcount", int'(playerCount), m_pc);

      // player cooldown spans six frames
      do_reset();
      fif.playerX = -11'sd5;
      fif.playerY = 11'sd7;
      expect_grant(1'b0);
      fif.playerReq = 1'b1;
      wait_gnt(1'b0, 3, "t4_g1");
      frames(3);
      fif.playerReq = 1'b1;
      frames(2);
      check("t4_cd_hold", n_pg, 1);
      expect_grant(1'b0);
      startOfFrame = 1'b1;
      cycle();
      startOfFrame = 1'b0;
      wait_gnt(1'b0, 2, "t4_g2_after_6th");

      // full pool, release, inactive release
      do_reset();
      fif.playerX = -11'sd20;
      fif.playerY = 11'sd300;
      fif.alienX = 11'sd200;
      fif.alienY = 11'sd100;
      fif.alienSpeed = 11'sd96;
      expect_grant(1'b0);
      expect_grant(1'b1);
      fif.playerReq = 1'b1;
      fif.alienReq = 1'b1;
      wait_gnt(1'b1, 4, "t5_a1");
      frames(7);
      expect_grant(1'b1);
      expect_grant(1'b0);
      fif.playerReq = 1'b1;
      fif.alienReq = 1'b1;
      wait_gnt(1'b0, 5, "t5_p2");
      frames(4);
      expect_grant(1'b1);
      fif.alienReq = 1'b1;
      wait_gnt(1'b1, 3, "t5_a3");
      check("t5_full_mask", int'(activeSlots), 31);
      check("t5_owner", int'(slotOwner), int'(m_owner));
      check("t5_acount", int'(alienCount), 3);
      frames(4);
      fif.alienReq = 1'b1;
      repeat (6) cycle();
      check("t5_full_block", n_ag, 3);
      release_slots(5'b00100);
      expect_grant(1'b1);
      wait_gnt(1'b1, 2, "t5_after_release");
      release_slots(5'b10000);
      release_slots(5'b10000);
      check("t5_inactive_acount", int'(alienCount), m_ac);
      check("t5_inactive_pcount", int'(playerCount), m_pc);
      check("t5_inactive_mask", int'(activeSlots), int'(m_active));

      // pause freezes grants and cooldowns but not releases
      do_reset();
      fif.playerX = 11'sd5;
      fif.playerY = 11'sd6;
      fif.alienX = 11'sd1;
      fif.alienY = 11'sd2;
      fif.alienSpeed = 11'sd3;
      expect_grant(1'b0);
      fif.playerReq = 1'b1;
      wait_gnt(1'b0, 3, "t6_g1");
      frames(2);
      pause = 1'b1;
      fif.playerReq = 1'b1;
      fif.alienReq = 1'b1;
      frames(8);
      check("t6_pause_pg", n_pg, 1);
      check("t6_pause_ag", n_ag, 0);
      release_slots(5'b00001);
      check("t6_release_paused", int'(activeSlots), 0);
      check("t6_pcount_paused", int'(playerCount), 0);
      pause = 1'b0;
      expect_grant(1'b1);
      wait_gnt(1'b1, 3, "t6_alien_unpause");
      frames(3);
      check("t6_cd_frozen", n_pg, 1);
      expect_grant(1'b0);
      startOfFrame = 1'b1;
      cycle();
      startOfFrame = 1'b0;
      wait_gnt(1'b0, 2, "t6_player_after_cd");

      // asynchronous reset in the middle of a grant cycle
      do_reset();
      fif.playerX = 11'sd7;
      fif.playerY = 11'sd8;
      expect_grant(1'b0);
      fif.playerReq = 1'b1;
      cycle();
      check("t7_in_grant", n_pg, 1);
      #2;
      resetN = 1'b0;
      #1;
      check("t7_load", int'(fif.slotLoad), 0);
      check("t7_gnt", int'({fif.alienGnt, fif.playerGnt}), 0);
      check("t7_active", int'(activeSlots), 0);
      check("t7_pcount", int'(playerCount), 0);
      check("t7_x", int'(fif.initialX), 0);
      fif.playerReq = 1'b0;
      drop_p = 1'b0;
      @(negedge clk);

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rocket_slot_arbiter.md
# rocket_slot_arbiter

Allocates the shared pool of rocket slots (single-rocket controllers) between the player fire path and the alien fire scheduler. Enforces per-owner rocket quotas and per-owner frame-based cooldowns, arbitrates simultaneous requests round-robin, and issues a one-cycle load strobe carrying launch position and speed to the chosen slot. Sits between the fire sources and the rocket object array, and collects hit and border releases from the collision logic.

## Interface
- NUM_SLOTS, 5, total rocket slots
- PLAYER_MAX, 2, maximum simultaneous player rockets
- ALIEN_MAX, 3, maximum simultaneous alien rockets
- PLAYER_CD, 6, frames between player grants
- ALIEN_CD, 3, frames between alien grants
- PLAYER_SPEED, -128, player launch speed (pixels/64 per frame)

- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- pause  in  1  level; freezes allocation and cooldowns
- playerReq  in  1  level request; held until playerGnt
- playerX, playerY  in  11 signed  player launch point
- alienReq  in  1  level request; held until alienGnt
- alienX, alienY  in  11 signed  alien launch point
- alienSpeed  in  11 signed  alien launch speed
- releaseSlot  in  NUM_SLOTS  one bit per slot; frees the slot (hit or border)
- playerGnt, alienGnt  out  1  one-cycle grant pulse
- slotLoad  out  NUM_SLOTS  one-hot, one-cycle load strobe
- initialX, initialY, initialSpeed  out  11 signed  launch data, valid while slotLoad != 0
- activeSlots  out  NUM_SLOTS  busy mask
- slotOwner  out  NUM_SLOTS  1 = alien, 0 = player; valid where active
- playerCount, alienCount  out  3  rockets currently owned

## Operation
- Reset: every output is 0, FSM in IDLE, both cooldowns 0, lastWinner = alien.
- FSM states:
  - IDLE: samples requests.
  - GRANT: drives the grant for one cycle, then returns to IDLE.
  - PAUSED: entered from IDLE or GRANT when pause=1. GRANT still completes its load before the FSM moves to PAUSED. Returns to IDLE when pause=0.
- Eligibility of a requester: req=1, at least one slot free, owner count < quota, owner cooldown = 0.
- Arbitration:
  - One eligible requester: it wins.
  - Both eligible: the requester that is not lastWinner wins, and lastWinner updates.
- Allocation:
  - The winner takes the lowest-index free slot, using the registered activeSlots.
  - On entry to GRANT: set the slot's active bit, write slotOwner, increment the owner count, load the owner cooldown (PLAYER_CD or ALIEN_CD), and register the launch data.
  - Player launch data: initialX = playerX + 32, initialY = playerY, initialSpeed = PLAYER_SPEED.
  - Alien launch data: alienX, alienY, alienSpeed passed through.
- Release:
  - A releaseSlot bit on an active slot clears it and decrements that owner's count.
  - A releaseSlot bit on an inactive slot is ignored.
  - A release and an allocation of the same slot in the same cycle cannot occur, because allocation only picks registered-free slots. A freed slot is allocatable the next cycle.
- Cooldowns:
  - Each cooldown decrements by 1 on startOfFrame when not paused, saturating at 0.
  - A load in the same cycle overrides the decrement.
- Counts never exceed their quota, and playerCount + alienCount always equals popcount(activeSlots).
- Releases are processed in all states, including PAUSED.

## Timing
- Request sampled in IDLE at edge n → grant, slotLoad and launch data are high for exactly the cycle after edge n. activeSlots updates at the same edge.
- Requests are not sampled in GRANT. The minimum spacing between grants is 2 cycles.
- A requester must drop req at the edge that ends the gnt cycle. A req still high in the next IDLE cycle is a new request.
- All outputs are registered. There is no combinational path from input to output.
- Reset mid-GRANT: all strobes drop immediately (asynchronous), the pending load is lost, and all slots become free.

## Structure
- Shared package (rocket_pkg) holds:
  - the FSM state enum {IDLE, GRANT, PAUSED};
  - the owner enum {OWNER_PLAYER, OWNER_ALIEN};
  - the coordinate type logic signed [10:0];
  - the PLAYER_X_OFFSET = 32 constant.
- One sub-module, slot_pool: busy mask, owner bits, lowest-free priority encoder, per-owner counters. The arbiter FSM and cooldowns stay in the top module.

## Test plan
- Reset, then playerReq=1 with playerX=100, playerY=400 → one cycle later: playerGnt=1, slotLoad=5'b00001, initialX=132, initialY=400, initialSpeed=-128, playerCount=1.
- Both requests held with both cooldowns 0 from reset → player granted first. After the player cooldown is forced to 0 and both request again, the alien wins (round-robin).
- Player requests 3 times, with 6 frames between requests → grants to slots 0 and 1 only; the third request waits. releaseSlot=5'b00010 → next grant goes to slot 1.
- Player grant, then playerReq again after 3 frames → no grant until the 6th startOfFrame following the grant.
- All 5 slots filled (2 player, 3 alien), alienReq held → no grant. releaseSlot=5'b00100 on an alien slot → alienGnt with slotLoad=5'b00100 within 2 cycles. Release of an inactive slot leaves the counts unchanged.
- pause=1 while requests are held → no grants and cooldowns frozen, while releases still clear slots. Assert resetN=0 during GRANT → all outputs 0 asynchronously.
